// File: rtl/rsa_pkg.sv
// Shared sizing defaults and FSM encodings for the rsa4k host-side controller.
package rsa_pkg;
    localparam int DEF_WIDTH  = 4096;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_NW     = DEF_WIDTH / DEF_WORD_W;
    localparam int N_OPS      = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
endpackage

// File: rtl/rsa_host_ctrl_if.sv
// Word-serial host stream: operand words in, result words out, valid/ready on both.
interface rsa_host_ctrl_if
    import rsa_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rsa_word_shifter.sv
// Wide register built from WORD_W slices: word-indexed write, full-width load, word-indexed read.
module rsa_word_shifter
    import rsa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clr,
    input  logic                              wr_en,
    input  logic [$clog2(WIDTH/WORD_W)-1:0]   wr_idx,
    input  logic [WORD_W-1:0]                 wr_data,
    input  logic                              ld_en,
    input  logic [WIDTH-1:0]                  ld_data,
    input  logic [$clog2(WIDTH/WORD_W)-1:0]   rd_idx,
    output logic [WORD_W-1:0]                 rd_data,
    output logic [WIDTH-1:0]                  data_o
);
    localparam int NW = WIDTH / WORD_W;
    localparam int IW = $clog2(NW);

    for (genvar gi = 0; gi < NW; gi++) begin : g_word
        logic [WORD_W-1:0] word_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_q <= '0;
            end else if (clr) begin
                word_q <= '0;
            end else if (ld_en) begin
                word_q <= ld_data[gi*WORD_W +: WORD_W];
            end else if (wr_en && (wr_idx == IW'(gi))) begin
                word_q <= wr_data;
            end
        end

        assign data_o[gi*WORD_W +: WORD_W] = word_q;
    end

    assign rd_data = data_o[rd_idx*WORD_W +: WORD_W];
endmodule

// File: rtl/rsa_host_ctrl.sv
// Host-side initiator for rsa4k: assembles operands from a word stream, runs the
// go/done handshake, then streams the captured cypher back out least-significant word first.
module rsa_host_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    rsa_host_ctrl_if.slave   host,
    output logic             busy,
    output logic             err,
    output logic             go,
    output logic [WIDTH-1:0] message,
    output logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] modulus,
    input  logic             done,
    input  logic [WIDTH-1:0] cypher
);
    localparam int NW = WIDTH / WORD_W;
    localparam int IW = $clog2(NW);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [IW-1:0]     word_q, word_d, word_nxt;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              go_q, go_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              op_clr, op_wr, res_ld, last_beat;
    logic [WORD_W-1:0] res_word;
    logic [WIDTH-1:0]  op_data [N_OPS];
    logic [WORD_W-1:0] op_rd_unused [N_OPS];
    logic [WIDTH-1:0]  res_data_unused;

    assign word_nxt  = word_q + 1'b1;
    assign last_beat = (sel_q == 2'd2) && (word_q == IW'(NW-1));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        op_clr      = 1'b0;
        op_wr       = 1'b0;
        res_ld      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                sel_d   = '0;
                word_d  = '0;
            end
            ST_LOAD: begin
                if (host.in_valid && in_ready_q) begin
                    if (host.in_last && !last_beat) begin
                        // Early in_last: drop the whole frame so the host restarts cleanly.
                        err_d  = 1'b1;
                        op_clr = 1'b1;
                        sel_d  = '0;
                        word_d = '0;
                    end else begin
                        op_wr = 1'b1;
                        if (last_beat) begin
                            err_d   = !host.in_last;
                            state_d = ST_RUN;
                            sel_d   = '0;
                            word_d  = '0;
                        end else if (word_q == IW'(NW-1)) begin
                            sel_d  = sel_q + 2'd1;
                            word_d = '0;
                        end else begin
                            word_d = word_nxt;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (done) begin
                    // The result register is being loaded this edge, so word 0 comes straight from cypher.
                    res_ld      = 1'b1;
                    state_d     = ST_DRAIN;
                    word_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = cypher[WORD_W-1:0];
                    out_last_d  = (NW == 1);
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && host.out_ready) begin
                    if (word_q == IW'(NW-1)) begin
                        state_d     = ST_RELEASE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        word_d     = word_nxt;
                        out_data_d = res_word;
                        out_last_d = (word_nxt == IW'(NW-1));
                    end
                end
            end
            ST_RELEASE: begin
                if (!done) begin
                    state_d = ST_LOAD;
                    sel_d   = '0;
                    word_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_LOAD);
        go_d       = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            go_q        <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            go_q        <= go_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_op
        rsa_word_shifter #(.WIDTH(WIDTH), .WORD_W(WORD_W)) u_op (
            .clk     (clk),
            .reset   (reset),
            .clr     (op_clr),
            .wr_en   (op_wr && (sel_q == 2'(gi))),
            .wr_idx  (word_q),
            .wr_data (host.in_data),
            .ld_en   (1'b0),
            .ld_data ('0),
            .rd_idx  ('0),
            .rd_data (op_rd_unused[gi]),
            .data_o  (op_data[gi])
        );
    end

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD_W(WORD_W)) u_result (
        .clk     (clk),
        .reset   (reset),
        .clr     (1'b0),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (res_ld),
        .ld_data (cypher),
        .rd_idx  (word_nxt),
        .rd_data (res_word),
        .data_o  (res_data_unused)
    );

    assign host.in_ready  = in_ready_q;
    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;
    assign host.out_last  = out_last_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign go             = go_q;
    assign message        = op_data[0];
    assign exponent       = op_data[1];
    assign modulus        = op_data[2];
endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Directed bench for rsa_host_ctrl with a small behavioural mod-exp engine standing in for rsa4k.
module tb_rsa_host_ctrl;
    localparam int WIDTH  = 4096;
    localparam int WORD_W = 32;
    localparam int NW     = WIDTH / WORD_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy, err, go, done;
    logic [WIDTH-1:0] message, exponent, modulus, cypher;
    int               n_vec = 0;
    int               n_err = 0;

    rsa_host_ctrl_if #(.WORD_W(WORD_W)) hif ();

    rsa_host_ctrl #(.WIDTH(WIDTH), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (hif),
        .busy     (busy),
        .err      (err),
        .go       (go),
        .message  (message),
        .exponent (exponent),
        .modulus  (modulus),
        .done     (done),
        .cypher   (cypher)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] engine_model(input logic [WIDTH-1:0] m, e, n);
        longint unsigned b, r, ee, nn;
        if (m[WIDTH-1:64] != '0 || e[WIDTH-1:64] != '0 || n[WIDTH-1:64] != '0) return '1;
        nn = n[63:0];
        if (nn == 0) return '0;
        b  = m[63:0] % nn;
        r  = 64'd1 % nn;
        ee = e[63:0];
        while (ee != 0) begin
            if (ee[0]) r = (r * b) % nn;
            b  = (b * b) % nn;
            ee = ee >> 1;
        end
        return WIDTH'(r);
    endfunction

    task automatic send_beat(input logic [WORD_W-1:0] d, input logic last);
        int guard = 0;
        hif.in_valid = 1'b1;
        hif.in_data  = d;
        hif.in_last  = last;
        while (hif.in_ready !== 1'b1 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) begin
            n_vec++; n_err++;
            $display("FAIL send_beat: in_ready=%b after %0d cycles, required 1", hif.in_ready, guard);
        end
        @(posedge clk); #1;
        hif.in_valid = 1'b0;
        hif.in_last  = 1'b0;
    endtask

    task automatic do_load(input logic [63:0] m, e, n, input bit gaps, input bit pulse_done, input bit mark_last);
        logic [WIDTH-1:0] ops [3];
        logic [WIDTH-1:0] cur;
        ops[0] = WIDTH'(m);
        ops[1] = WIDTH'(e);
        ops[2] = WIDTH'(n);
        for (int b = 0; b < 3*NW; b++) begin
            cur = ops[b / NW];
            if (pulse_done && b == 50) done = 1'b1;
            if (pulse_done && b == 53) begin
                done = 1'b0;
                n_vec++;
                if (go !== 1'b0 || hif.in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL done_in_load: go=%b in_ready=%b, required go=0 in_ready=1", go, hif.in_ready);
                end
            end
            if (b == 3*NW-1) begin
                n_vec++;
                if (go !== 1'b0) begin
                    n_err++;
                    $display("FAIL go_early: go=%b before final beat, required 0", go);
                end
            end
            send_beat(cur[(b % NW)*WORD_W +: WORD_W], mark_last && (b == 3*NW-1));
            if (gaps && b < 3*NW-1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        n_vec++;
        if (go !== 1'b1 || hif.in_ready !== 1'b0 || busy !== 1'b1 || err !== !mark_last) begin
            n_err++;
            $display("FAIL go_rise: go=%b in_ready=%b busy=%b err=%b, required go=1 in_ready=0 busy=1 err=%b",
                     go, hif.in_ready, busy, err, !mark_last);
        end
        n_vec++;
        if (message !== ops[0] || exponent !== ops[1] || modulus !== ops[2]) begin
            n_err++;
            $display("FAIL operands: m=%h e=%h n=%h, required m=%h e=%h n=%h",
                     message[63:0], exponent[63:0], modulus[63:0], m, e, n);
        end
    endtask

    task automatic engine_respond(input int lat, input logic [WORD_W-1:0] exp_w0);
        int guard = 0;
        while (go !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        if (guard >= 100) begin
            n_vec++; n_err++;
            $display("FAIL wait_go: go=%b, required 1", go);
            return;
        end
        repeat (lat) begin @(posedge clk); #1; end
        n_vec++;
        if (go !== 1'b1 || hif.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL run_hold: go=%b out_valid=%b, required go=1 out_valid=0", go, hif.out_valid);
        end
        cypher = engine_model(message, exponent, modulus);
        done   = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (go !== 1'b0 || hif.out_valid !== 1'b1 || hif.out_data !== exp_w0) begin
            n_err++;
            $display("FAIL capture: go=%b out_valid=%b out_data=%h, required go=0 out_valid=1 out_data=%h",
                     go, hif.out_valid, hif.out_data, exp_w0);
        end
        cypher = '1;
    endtask

    task automatic drain_result(input logic [WORD_W-1:0] exp_w0, input bit stall);
        int                j = 0;
        int                guard = 0;
        bit                held_v = 0;
        logic [WORD_W-1:0] held_d = '0;
        logic              held_l = 1'b0;
        logic [WORD_W-1:0] exp_d;
        while (j < NW && guard < 5000) begin
            hif.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held_v) begin
                n_vec++;
                if (hif.out_valid !== 1'b1 || hif.out_data !== held_d || hif.out_last !== held_l) begin
                    n_err++;
                    $display("FAIL stall_hold word %0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             j, hif.out_valid, hif.out_data, hif.out_last, held_d, held_l);
                end
            end
            held_v = 0;
            if (hif.out_valid === 1'b1) begin
                if (hif.out_ready) begin
                    exp_d = (j == 0) ? exp_w0 : '0;
                    n_vec++;
                    if (hif.out_data !== exp_d || hif.out_last !== (j == NW-1)) begin
                        n_err++;
                        $display("FAIL drain word %0d: data=%h last=%b, required data=%h last=%b",
                                 j, hif.out_data, hif.out_last, exp_d, (j == NW-1));
                    end
                    j++;
                end else begin
                    held_v = 1;
                    held_d = hif.out_data;
                    held_l = hif.out_last;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        hif.out_ready = 1'b0;
        n_vec++;
        if (j < NW || hif.out_valid !== 1'b0 || hif.out_last !== 1'b0) begin
            n_err++;
            $display("FAIL drain_end: words=%0d out_valid=%b out_last=%b, required words=%0d out_valid=0 out_last=0",
                     j, hif.out_valid, hif.out_last, NW);
        end
    endtask

    task automatic release_done(input int hold);
        for (int i = 0; i < hold; i++) begin
            n_vec++;
            if (hif.in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL release_hold cycle %0d: in_ready=%b busy=%b, required in_ready=0 busy=1",
                         i, hif.in_ready, busy);
            end
            @(posedge clk); #1;
        end
        done = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (hif.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL release_exit: in_ready=%b busy=%b, required in_ready=1 busy=0", hif.in_ready, busy);
        end
    endtask

    task automatic full_run(input logic [63:0] m, e, n, input logic [WORD_W-1:0] exp_w0,
                            input bit gaps, input bit pulse, input bit mark_last, input bit stall, input int hold);
        do_load(m, e, n, gaps, pulse, mark_last);
        engine_respond($urandom_range(1, 40), exp_w0);
        drain_result(exp_w0, stall);
        release_done(hold);
    endtask

    task automatic check_reset_values(input string tag);
        n_vec++;
        if (go !== 1'b0 || hif.in_ready !== 1'b0 || hif.out_valid !== 1'b0 || hif.out_last !== 1'b0 ||
            err !== 1'b0 || busy !== 1'b1 || message !== '0 || modulus !== '0) begin
            n_err++;
            $display("FAIL %s: go=%b in_ready=%b out_valid=%b out_last=%b err=%b busy=%b m0=%h, required 0 0 0 0 0 1 0",
                     tag, go, hif.in_ready, hif.out_valid, hif.out_last, err, busy, message[63:0]);
        end
    endtask

    task automatic release_reset(input string tag);
        reset = 1'b1;
        n_vec++;
        if (hif.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s_pre: in_ready=%b right after release, required 0", tag, hif.in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (hif.in_ready !== 1'b1 || busy !== 1'b0 || go !== 1'b0) begin
            n_err++;
            $display("FAIL %s_post: in_ready=%b busy=%b go=%b, required 1 0 0", tag, hif.in_ready, busy, go);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_reset_values("reset_values");
        repeat (2) begin @(posedge clk); #1; end
        release_reset("reset_release");
    endtask

    task automatic test_first_result();
        full_run(64'd8, 64'd13, 64'd77, 32'd50, 0, 0, 1, 0, 2);
    endtask

    task automatic test_second_result();
        full_run(64'd50, 64'd37, 64'd77, 32'd8, 0, 0, 1, 0, 10);
    endtask

    task automatic test_framing();
        for (int b = 0; b < 100; b++) send_beat((b == 0) ? 32'd8 : 32'd0, 1'b0);
        send_beat(32'd0, 1'b1);
        n_vec++;
        if (err !== 1'b1 || hif.in_ready !== 1'b1 || go !== 1'b0 || message !== '0) begin
            n_err++;
            $display("FAIL framing_err: err=%b in_ready=%b go=%b m0=%h, required err=1 in_ready=1 go=0 m0=0",
                     err, hif.in_ready, go, message[63:0]);
        end
        @(posedge clk); #1;
        n_vec++;
        if (err !== 1'b0 || go !== 1'b0) begin
            n_err++;
            $display("FAIL framing_pulse: err=%b go=%b one cycle later, required err=0 go=0", err, go);
        end
        full_run(64'd8, 64'd13, 64'd77, 32'd50, 0, 0, 1, 0, 1);
    endtask

    task automatic test_drain_stall();
        full_run(64'd8, 64'd13, 64'd77, 32'd50, 0, 0, 1, 1, 3);
    endtask

    task automatic test_reset_mid();
        do_load(64'd8, 64'd13, 64'd77, 0, 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check_reset_values("reset_in_run");
        @(posedge clk); #1;
        release_reset("reset_run_release");
        do_load(64'd8, 64'd13, 64'd77, 0, 0, 1);
        engine_respond(5, 32'd50);
        hif.out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        hif.out_ready = 1'b0;
        n_vec++;
        if (hif.out_valid !== 1'b1 || hif.out_data !== 32'd0 || hif.out_last !== 1'b0) begin
            n_err++;
            $display("FAIL mid_drain: out_valid=%b out_data=%h out_last=%b, required 1 0 0",
                     hif.out_valid, hif.out_data, hif.out_last);
        end
        reset = 1'b0;
        done  = 1'b0;
        #1;
        check_reset_values("reset_in_drain");
        @(posedge clk); #1;
        release_reset("reset_drain_release");
    endtask

    task automatic test_gaps_done_pulse();
        full_run(64'd8, 64'd13, 64'd77, 32'd50, 1, 1, 1, 0, 2);
    endtask

    task automatic test_missing_last();
        full_run(64'd50, 64'd37, 64'd77, 32'd8, 0, 0, 0, 0, 1);
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: err=%b after missing-last run, required 0", err);
        end
    endtask

    initial begin
        hif.in_valid  = 1'b0;
        hif.in_data   = '0;
        hif.in_last   = 1'b0;
        hif.out_ready = 1'b0;
        done          = 1'b0;
        cypher        = '0;
        test_reset();
        test_first_result();
        test_second_result();
        test_framing();
        test_drain_stall();
        test_reset_mid();
        test_gaps_done_pulse();
        test_missing_last();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
